// File: rtl/l2_mem_line_xfer.sv
// Moves whole cache lines between L2 and main memory on a miss: optional dirty-victim write-back, then a beat-by-beat fill.
// Optional CRITICAL_WORD_FIRST_EN starts the fill at the beat holding the requested word.
module l2_mem_line_xfer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_fill_addr,
   input  logic                     req_wb,
   input  logic [ADDR_W-1:0]        req_wb_addr,
   output logic [$clog2(BEATS)-1:0] wb_beat_idx,
   input  logic [DATA_W-1:0]        wb_data,
   output logic                     fill_valid,
   output logic [$clog2(BEATS)-1:0] fill_beat,
   output logic [DATA_W-1:0]        fill_data,
   output logic                     done,
   output logic                     mem_stb,
   output logic                     mem_we_n,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack
);

   localparam int IDX_W  = $clog2(BEATS);
   localparam int OFF_W  = IDX_W + 3;
   localparam int LINE_W = ADDR_W - OFF_W;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB,
      S_TURN,
      S_FILL,
      S_LAST,
      S_DONE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  beat_cnt;
   logic [IDX_W-1:0]  fill_idx;
   logic [IDX_W-1:0]  fill_idx_next;
   logic [IDX_W-1:0]  req_start;
   logic [LINE_W-1:0] fill_line;
   logic [LINE_W-1:0] wb_line;
   logic              unused_offset_bits;

`ifdef CRITICAL_WORD_FIRST_EN
   logic [IDX_W-1:0]  start_beat;
   assign req_start = req_fill_addr[OFF_W-1:3];
   assign fill_idx  = start_beat + beat_cnt;
`else
   assign req_start = '0;
   assign fill_idx  = beat_cnt;
`endif

   // Beat index wraps inside the line; it never carries into the line base.
   assign fill_idx_next      = fill_idx + IDX_W'(1);
   assign unused_offset_bits = ^{req_fill_addr[OFF_W-1:0], req_wb_addr[OFF_W-1:0]};

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                   input logic [IDX_W-1:0]  idx);
      return {line, idx, 3'b000};
   endfunction

   // NOTE: all state and outputs update with non-blocking assignments so every
   // branch below reads the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         beat_cnt    <= '0;
         fill_line   <= '0;
         wb_line     <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
         start_beat  <= '0;
`endif
         req_ready   <= 1'b1;
         wb_beat_idx <= '0;
         fill_valid  <= 1'b0;
         fill_beat   <= '0;
         fill_data   <= '0;
         done        <= 1'b0;
         mem_stb     <= 1'b0;
         mem_we_n    <= 1'b1;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         fill_valid <= 1'b0;
         done       <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  fill_line <= req_fill_addr[ADDR_W-1:OFF_W];
                  wb_line   <= req_wb_addr[ADDR_W-1:OFF_W];
`ifdef CRITICAL_WORD_FIRST_EN
                  start_beat <= req_start;
`endif
                  beat_cnt  <= '0;
                  req_ready <= 1'b0;
                  mem_stb   <= 1'b1;
                  if (req_wb) begin
                     // wb_beat_idx is 0 here, so wb_data already holds victim beat 0.
                     state       <= S_WB;
                     mem_we_n    <= 1'b0;
                     mem_addr    <= beat_addr(req_wb_addr[ADDR_W-1:OFF_W], '0);
                     mem_wdata   <= wb_data;
                     wb_beat_idx <= IDX_W'(1);
                  end else begin
                     state    <= S_FILL;
                     mem_we_n <= 1'b1;
                     mem_addr <= beat_addr(req_fill_addr[ADDR_W-1:OFF_W], req_start);
                  end
               end
            end
            S_WB: begin
               if (mem_ack) begin
                  if (beat_cnt == LAST_BEAT) begin
                     mem_stb     <= 1'b0;
                     beat_cnt    <= '0;
                     wb_beat_idx <= '0;
                     state       <= S_TURN;
                  end else begin
                     beat_cnt    <= beat_cnt + IDX_W'(1);
                     mem_addr    <= beat_addr(wb_line, beat_cnt + IDX_W'(1));
                     mem_wdata   <= wb_data;
                     wb_beat_idx <= wb_beat_idx + IDX_W'(1);
                  end
               end
            end
            S_TURN: begin
               mem_stb  <= 1'b1;
               mem_we_n <= 1'b1;
               mem_addr <= beat_addr(fill_line, fill_idx);
               state    <= S_FILL;
            end
            S_FILL: begin
               if (mem_ack) begin
                  fill_valid <= 1'b1;
                  fill_data  <= mem_rdata;
                  fill_beat  <= fill_idx;
                  if (beat_cnt == LAST_BEAT) begin
                     mem_stb  <= 1'b0;
                     beat_cnt <= '0;
                     state    <= S_LAST;
                  end else begin
                     beat_cnt <= beat_cnt + IDX_W'(1);
                     mem_addr <= beat_addr(fill_line, fill_idx_next);
                  end
               end
            end
            S_LAST: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_line_xfer.sv
// Directed bench for l2_mem_line_xfer: table of line transfers plus stall, reset, busy and idle-ack sequences.
// Fill order expectations follow CRITICAL_WORD_FIRST_EN when the bench is built with it.
module tb_l2_mem_line_xfer;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int BEATS  = 4;

`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ADDR_W-1:0] req_fill_addr = '0;
   logic              req_wb = 1'b0;
   logic [ADDR_W-1:0] req_wb_addr = '0;
   logic [1:0]        wb_beat_idx;
   logic [DATA_W-1:0] wb_data;
   logic              fill_valid;
   logic [1:0]        fill_beat;
   logic [DATA_W-1:0] fill_data;
   logic              done;
   logic              mem_stb;
   logic              mem_we_n;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;

   always #5 clk = ~clk;

   l2_mem_line_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_fill_addr(req_fill_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
      .wb_beat_idx(wb_beat_idx), .wb_data(wb_data),
      .fill_valid(fill_valid), .fill_beat(fill_beat), .fill_data(fill_data), .done(done),
      .mem_stb(mem_stb), .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we_n;
      logic [63:0] wdata;
      int          cyc;
   } bus_beat_t;

   typedef struct {
      logic [1:0]  beat;
      logic [63:0] data;
      int          cyc;
   } fill_rec_t;

   typedef struct {
      logic [31:0] fill_addr;
      logic        wb;
      logic [31:0] wb_addr;
      logic [31:0] exp_fill_base;
      logic [31:0] exp_wb_base;
      logic [1:0]  exp_start;
      bit          busy;
   } vec_t;

   bus_beat_t bus_q[$];
   fill_rec_t fill_q[$];
   int        done_q[$];
   int        cyc = 0;
   bit        resp_en = 1'b0;
   int        checks = 0;
   int        failures = 0;
   vec_t      vecs[5];
   vec_t      post_rst;

   function automatic logic [63:0] victim_data(input logic [1:0] i);
      return 64'hDEAD_BEEF_0000_0000 + 64'(i) * 64'h0000_0000_0101_0101;
   endfunction

   function automatic logic [63:0] rdata_model(input logic [31:0] a);
      return {a ^ 32'h5A5A_5A5A, ~a};
   endfunction

   // L2 victim storage: combinational read indexed by wb_beat_idx.
   assign wb_data = victim_data(wb_beat_idx);

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor and auto-acking memory model, both sampling on the falling edge.
   always @(negedge clk) begin
      if (fill_valid) fill_q.push_back('{beat: fill_beat, data: fill_data, cyc: cyc});
      if (done) done_q.push_back(cyc);
      if (resp_en) begin
         if (mem_stb) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata_model(mem_addr);
            bus_q.push_back('{addr: mem_addr, we_n: mem_we_n, wdata: mem_wdata, cyc: cyc});
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   // NOTE: stimulus changes 1 time unit after the falling edge, well clear of the rising edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"},   64'(req_ready),   64'd1);
      check({tag, "_mem_stb"},     64'(mem_stb),     64'd0);
      check({tag, "_mem_we_n"},    64'(mem_we_n),    64'd1);
      check({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
      check({tag, "_mem_wdata"},   mem_wdata,        64'd0);
      check({tag, "_fill_valid"},  64'(fill_valid),  64'd0);
      check({tag, "_fill_beat"},   64'(fill_beat),   64'd0);
      check({tag, "_fill_data"},   fill_data,        64'd0);
      check({tag, "_done"},        64'(done),        64'd0);
      check({tag, "_wb_beat_idx"}, 64'(wb_beat_idx), 64'd0);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_q.size() == 0; i++) tick();
      check("done_within_budget", 64'(done_q.size() != 0), 64'd1);
   endtask

   task automatic clear_logs();
      bus_q.delete();
      fill_q.delete();
      done_q.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int         t0;
      int         nwb;
      logic [1:0] idx;
      clear_logs();
      check("ready_before_req", 64'(req_ready), 64'd1);
      req_fill_addr = v.fill_addr;
      req_wb        = v.wb;
      req_wb_addr   = v.wb_addr;
      req_valid     = 1'b1;
      t0            = cyc;
      tick();
      req_valid = 1'b0;
      check("ready_low_after_accept", 64'(req_ready), 64'd0);
      if (v.busy) begin
         for (int i = 0; i < 50 && fill_q.size() == 0; i++) tick();
         check("busy_fill_started", 64'(fill_q.size() != 0), 64'd1);
         req_fill_addr = 32'h0000_9000;
         req_wb        = 1'b1;
         req_wb_addr   = 32'h0000_C000;
         req_valid     = 1'b1;
         tick();
         req_valid = 1'b0;
      end
      wait_done(100);
      tick();
      check("ready_after_done", 64'(req_ready), 64'd1);
      repeat (6) tick();

      nwb = v.wb ? BEATS : 0;
      check("beat_count", 64'(bus_q.size()), 64'(nwb + BEATS));
      check("fill_count", 64'(fill_q.size()), 64'(BEATS));
      check("done_count", 64'(done_q.size()), 64'd1);
      if (bus_q.size() == nwb + BEATS) begin
         check("first_stb_cycle", 64'(bus_q[0].cyc), 64'(t0 + 1));
         for (int k = 0; k < nwb; k++) begin
            check("wb_addr",  64'(bus_q[k].addr), 64'(v.exp_wb_base + 32'(k) * 32'd8));
            check("wb_we_n",  64'(bus_q[k].we_n), 64'd0);
            check("wb_wdata", bus_q[k].wdata, victim_data(2'(k)));
            if (k > 0) check("wb_back_to_back", 64'(bus_q[k].cyc - bus_q[k-1].cyc), 64'd1);
         end
         if (nwb > 0) check("turnaround_gap", 64'(bus_q[nwb].cyc - bus_q[nwb-1].cyc), 64'd2);
         for (int k = 0; k < BEATS; k++) begin
            idx = v.exp_start + 2'(k);
            check("fill_addr", 64'(bus_q[nwb+k].addr), 64'(v.exp_fill_base + (32'(idx) << 3)));
            check("fill_we_n", 64'(bus_q[nwb+k].we_n), 64'd1);
         end
      end
      if (fill_q.size() == BEATS && bus_q.size() == nwb + BEATS) begin
         for (int k = 0; k < BEATS; k++) begin
            idx = v.exp_start + 2'(k);
            check("fill_beat", 64'(fill_q[k].beat), 64'(idx));
            check("fill_data", fill_q[k].data, rdata_model(v.exp_fill_base + (32'(idx) << 3)));
            check("fill_latency", 64'(fill_q[k].cyc), 64'(bus_q[nwb+k].cyc + 1));
         end
         if (done_q.size() == 1)
            check("done_after_last_fill", 64'(done_q[0]), 64'(fill_q[BEATS-1].cyc + 1));
      end
   endtask

   initial begin
      vecs[0] = '{fill_addr: 32'h0000_1234, wb: 1'b0, wb_addr: 32'h0,
                  exp_fill_base: 32'h0000_1220, exp_wb_base: 32'h0,
                  exp_start: CWF ? 2'd2 : 2'd0, busy: 1'b0};
      vecs[1] = '{fill_addr: 32'h0000_0040, wb: 1'b1, wb_addr: 32'h0000_8000,
                  exp_fill_base: 32'h0000_0040, exp_wb_base: 32'h0000_8000,
                  exp_start: 2'd0, busy: 1'b0};
      vecs[2] = '{fill_addr: 32'h0000_0A38, wb: 1'b0, wb_addr: 32'h0,
                  exp_fill_base: 32'h0000_0A20, exp_wb_base: 32'h0,
                  exp_start: CWF ? 2'd3 : 2'd0, busy: 1'b0};
      vecs[3] = '{fill_addr: 32'h0000_FFFF, wb: 1'b1, wb_addr: 32'h1234_567F,
                  exp_fill_base: 32'h0000_FFE0, exp_wb_base: 32'h1234_5660,
                  exp_start: CWF ? 2'd3 : 2'd0, busy: 1'b0};
      vecs[4] = '{fill_addr: 32'h0000_7000, wb: 1'b0, wb_addr: 32'h0,
                  exp_fill_base: 32'h0000_7000, exp_wb_base: 32'h0,
                  exp_start: 2'd0, busy: 1'b1};
      post_rst = '{fill_addr: 32'h0000_6000, wb: 1'b0, wb_addr: 32'h0,
                   exp_fill_base: 32'h0000_6000, exp_wb_base: 32'h0,
                   exp_start: 2'd0, busy: 1'b0};

      tick();
      check_reset_vals("reset");
      tick();
      rst_n = 1'b1;
      tick();
      resp_en = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stalled ack on write-back beat 1, then acks held high across the turnaround.
      resp_en = 1'b0;
      mem_ack = 1'b0;
      clear_logs();
      req_fill_addr = 32'h0000_3000;
      req_wb        = 1'b1;
      req_wb_addr   = 32'h0000_2000;
      req_valid     = 1'b1;
      tick();
      req_valid = 1'b0;
      check("stall_b0_addr",  64'(mem_addr), 64'h2000);
      check("stall_b0_wdata", mem_wdata, victim_data(2'd0));
      check("stall_b0_we_n",  64'(mem_we_n), 64'd0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("stall_stb",   64'(mem_stb), 64'd1);
         check("stall_addr",  64'(mem_addr), 64'h2008);
         check("stall_wdata", mem_wdata, victim_data(2'd1));
         tick();
      end
      check("stall_addr_end", 64'(mem_addr), 64'h2008);
      mem_ack = 1'b1;
      tick();
      check("stall_b2_addr",  64'(mem_addr), 64'h2010);
      check("stall_b2_wdata", mem_wdata, victim_data(2'd2));
      tick();
      check("stall_b3_addr",  64'(mem_addr), 64'h2018);
      check("stall_b3_wdata", mem_wdata, victim_data(2'd3));
      tick();
      check("turn_stb_low", 64'(mem_stb), 64'd0);
      tick();
      check("turn_fill_stb",  64'(mem_stb), 64'd1);
      check("turn_fill_addr", 64'(mem_addr), 64'h3000);
      check("turn_fill_we_n", 64'(mem_we_n), 64'd1);
      check("no_fill_during_wb", 64'(fill_q.size()), 64'd0);
      mem_ack = 1'b0;
      resp_en = 1'b1;
      wait_done(100);
      repeat (4) tick();
      check("stall_fill_beats", 64'(bus_q.size()), 64'd4);
      check("stall_fill_count", 64'(fill_q.size()), 64'd4);
      if (bus_q.size() == 4 && fill_q.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            check("stall_fill_addr", 64'(bus_q[k].addr), 64'(32'h3000 + 32'(k) * 32'd8));
            check("stall_fill_beat", 64'(fill_q[k].beat), 64'(k));
            check("stall_fill_data", fill_q[k].data, rdata_model(32'h3000 + 32'(k) * 32'd8));
         end
      end

      // Acks while idle must not start anything.
      resp_en = 1'b0;
      mem_ack = 1'b1;
      clear_logs();
      repeat (3) begin
         tick();
         check("idle_ack_stb",   64'(mem_stb), 64'd0);
         check("idle_ack_ready", 64'(req_ready), 64'd1);
      end
      check("idle_ack_no_fill", 64'(fill_q.size()), 64'd0);
      check("idle_ack_no_done", 64'(done_q.size()), 64'd0);
      mem_ack = 1'b0;
      resp_en = 1'b1;
      tick();

      // Reset after two acked fill beats aborts the line.
      clear_logs();
      req_fill_addr = 32'h0000_5000;
      req_wb        = 1'b0;
      req_valid     = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 50 && fill_q.size() < 2; i++) tick();
      check("rst_two_fills_seen", 64'(fill_q.size()), 64'd2);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      repeat (3) tick();
      check("rst_no_more_fill", 64'(fill_q.size()), 64'd2);
      check("rst_no_done",      64'(done_q.size()), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("rst_release_stb", 64'(mem_stb), 64'd0);
      run_vec(post_rst);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
